// File: rtl/acorn_phase_ctrl_pkg.sv
// Shared definitions for the ACORN-128 sequencer: phase codes, default
// step constants and a helper that tells whether a phase performs steps.
package acorn_phase_ctrl_pkg;

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_INIT  = 3'd1;
   localparam logic [2:0] PH_AD    = 3'd2;
   localparam logic [2:0] PH_ENC   = 3'd3;
   localparam logic [2:0] PH_FINAL = 3'd4;
   localparam logic [2:0] PH_DONE  = 3'd5;

   localparam int DEF_AD_BITS     = 128;
   localparam int DEF_PT_BITS     = 128;
   localparam int DEF_INIT_STEPS  = 1792;
   localparam int DEF_FINAL_STEPS = 768;
   localparam int DEF_CNT_W       = 12;

   // INIT, AD, ENC and FINAL are the phases in which the datapath steps.
   function automatic logic is_active(input logic [2:0] ph);
      return (ph >= PH_INIT) && (ph <= PH_FINAL);
   endfunction

endpackage

// File: rtl/acorn_step_cnt.sv
// Step counter for one phase: counts enabled steps, wraps to zero after
// the supplied LAST value and flags when the current step is the last one.
module acorn_step_cnt #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   assign tc = (count == last);

   // Clear wins over enable; on the last step the counter restarts at zero
   // so the next phase begins at step 0 without a lost or repeated cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         if (tc) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/acorn_phase_ctrl.sv
// ACORN-128 phase sequencer: walks the state-update datapath through
// INIT, AD, ENC and FINAL one step per un-stalled cycle, supplies the
// ca/cb control bits and the step index, and pulses done at the end.
module acorn_phase_ctrl
   import acorn_phase_ctrl_pkg::*;
#(
   parameter int AD_BITS     = DEF_AD_BITS,
   parameter int PT_BITS     = DEF_PT_BITS,
   parameter int INIT_STEPS  = DEF_INIT_STEPS,
   parameter int FINAL_STEPS = DEF_FINAL_STEPS,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] count_ap,
   output logic             step_en,
   output logic             ca_out,
   output logic             cb_out
);

   localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_STEPS - 1);
   localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(AD_BITS + 255);
   localparam logic [CNT_W-1:0] ENC_LAST   = CNT_W'(PT_BITS + 255);
   localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(FINAL_STEPS - 1);
   localparam logic [CNT_W-1:0] AD_CA_END  = CNT_W'(AD_BITS + 128);
   localparam logic [CNT_W-1:0] PT_CA_END  = CNT_W'(PT_BITS + 128);

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] last_val;
   logic             active;
   logic             cnt_clr;
   logic             cnt_tc;

   assign active  = is_active(state);
   assign step_en = active & ~stall;
   assign busy    = active;
   assign done    = (state == PH_DONE);
   assign phase   = state;
   assign cnt_clr = ~active | abort;

   acorn_step_cnt #(
      .CNT_W (CNT_W)
   ) u_step_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (step_en),
      .last  (last_val),
      .count (count_ap),
      .tc    (cnt_tc)
   );

   // Select the final step index of the phase currently running.
   always_comb begin
      last_val = '0;
      case (state)
         PH_INIT:  last_val = INIT_LAST;
         PH_AD:    last_val = AD_LAST;
         PH_ENC:   last_val = ENC_LAST;
         PH_FINAL: last_val = FINAL_LAST;
         default:  last_val = '0;
      endcase
   end

   // Phase transitions: abort beats both stall and advance; a phase only
   // advances on a real (un-stalled) step at its last count.
   always_comb begin
      state_next = state;
      case (state)
         PH_IDLE: begin
            if (start) begin
               state_next = PH_INIT;
            end
         end
         PH_INIT, PH_AD, PH_ENC, PH_FINAL: begin
            if (abort) begin
               state_next = PH_IDLE;
            end else if (step_en && cnt_tc) begin
               case (state)
                  PH_INIT: state_next = PH_AD;
                  PH_AD:   state_next = PH_ENC;
                  PH_ENC:  state_next = PH_FINAL;
                  default: state_next = PH_DONE;
               endcase
            end
         end
         PH_DONE: state_next = PH_IDLE;
         default: state_next = PH_IDLE;
      endcase
   end

   // Phase register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PH_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ca/cb control bits: ca drops for the last 128 steps of AD and ENC,
   // cb is low only during encryption.
   always_comb begin
      ca_out = 1'b0;
      cb_out = 1'b0;
      case (state)
         PH_INIT: begin
            ca_out = 1'b1;
            cb_out = 1'b1;
         end
         PH_AD: begin
            ca_out = (count_ap < AD_CA_END);
            cb_out = 1'b1;
         end
         PH_ENC: begin
            ca_out = (count_ap < PT_CA_END);
            cb_out = 1'b0;
         end
         PH_FINAL: begin
            ca_out = 1'b1;
            cb_out = 1'b1;
         end
         default: begin
            ca_out = 1'b0;
            cb_out = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// Bench for acorn_phase_ctrl: directed runs with a phase/done scoreboard.
module tb_acorn_phase_ctrl;
   import acorn_phase_ctrl_pkg::*;

   localparam int CNT_W = 12;
   localparam int LAT   = 3328;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic             stall;
   logic             busy;
   logic             done;
   logic [2:0]       phase;
   logic [CNT_W-1:0] count_ap;
   logic             step_en;
   logic             ca_out;
   logic             cb_out;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         step_total = 0;
   logic [2:0] prev_phase = 3'd0;
   logic [2:0] exp_phase_q[$];
   int         exp_done_q[$];

   acorn_phase_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .phase    (phase),
      .count_ap (count_ap),
      .step_en  (step_en),
      .ca_out   (ca_out),
      .cb_out   (cb_out)
   );

   // Free-running clock and edge counter used to time the done pulse.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_error(input string name);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_busy"},     busy,     0);
      check_output({tag, "_done"},     done,     0);
      check_output({tag, "_phase"},    phase,    0);
      check_output({tag, "_count"},    count_ap, 0);
      check_output({tag, "_step_en"},  step_en,  0);
      check_output({tag, "_ca"},       ca_out,   0);
      check_output({tag, "_cb"},       cb_out,   0);
   endtask

   task automatic push_phases(input bit full, input int upto);
      for (int p = 1; p <= upto; p++) exp_phase_q.push_back(3'(p));
      if (full) exp_phase_q.push_back(PH_DONE);
      exp_phase_q.push_back(PH_IDLE);
   endtask

   // Pulse start for one edge; lat >= 0 registers the expected done cycle.
   task automatic apply_stimulus(input int lat);
      @(posedge clk);
      #1;
      start = 1'b1;
      if (lat >= 0) exp_done_q.push_back(cyc + 1 + lat);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_for(input logic [2:0] ph, input int cnt, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (phase == ph && int'(count_ap) == cnt) found = 1'b1;
      end
      if (!found) check_output($sformatf("wait_ph%0d_cnt%0d", ph, cnt), 0, 1);
   endtask

   // Monitor: pops the expected phase on every phase change and the
   // expected cycle on every done pulse; also counts datapath steps.
   initial begin
      forever begin
         @(negedge clk);
         if (step_en) step_total++;
         if (phase != prev_phase) begin
            if (exp_phase_q.size() == 0) flag_error("phase_change");
            else check_output("phase_seq", phase, exp_phase_q.pop_front());
            prev_phase = phase;
         end
         if (done) begin
            if (exp_done_q.size() == 0) flag_error("done_pulse");
            else check_output("done_cycle", cyc, exp_done_q.pop_front());
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      stall = 1'b0;
      #12;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] run 1: plain run with phase boundaries");
      base = step_total;
      push_phases(1'b1, 4);
      apply_stimulus(LAT);
      @(negedge clk);
      check_output("first_busy", busy, 1);
      check_output("first_phase", phase, 1);
      check_output("first_count", count_ap, 0);
      wait_for(PH_INIT, 1791, 2000);
      check_output("init_last_step_en", step_en, 1);
      check_output("init_ca", ca_out, 1);
      check_output("init_cb", cb_out, 1);
      @(negedge clk);
      check_output("ad_first_phase", phase, PH_AD);
      check_output("ad_first_count", count_ap, 0);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_for(PH_AD, 255, 400);
      check_output("ad255_ca", ca_out, 1);
      check_output("ad255_cb", cb_out, 1);
      @(negedge clk);
      check_output("ad256_count", count_ap, 256);
      check_output("ad256_ca", ca_out, 0);
      check_output("ad256_cb", cb_out, 1);
      wait_for(PH_AD, 383, 200);
      check_output("ad383_ca", ca_out, 0);
      wait_for(PH_ENC, 255, 400);
      check_output("enc255_ca", ca_out, 1);
      check_output("enc255_cb", cb_out, 0);
      @(negedge clk);
      check_output("enc256_ca", ca_out, 0);
      check_output("enc256_cb", cb_out, 0);
      wait_for(PH_FINAL, 0, 200);
      check_output("final_ca", ca_out, 1);
      check_output("final_cb", cb_out, 1);
      wait_for(PH_DONE, 0, 1000);
      check_output("done_high", done, 1);
      check_output("done_busy", busy, 0);
      check_output("done_step_en", step_en, 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_output("after_done_phase", phase, PH_IDLE);
      check_output("after_done_done", done, 0);
      check_output("run1_steps", step_total - base, LAT);
      repeat (20) @(negedge clk);

      $display("[TB] run 2: 10-cycle stall at INIT step 500");
      base = step_total;
      push_phases(1'b1, 4);
      apply_stimulus(LAT + 10);
      wait_for(PH_INIT, 499, 600);
      @(posedge clk);
      #1;
      stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output($sformatf("stall%0d_count", i), count_ap, 500);
         check_output($sformatf("stall%0d_step_en", i), step_en, 0);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      wait_for(PH_DONE, 0, 4000);
      @(negedge clk);
      check_output("run2_steps", step_total - base, LAT);

      $display("[TB] run 3: abort at AD step 100, then a fresh run");
      push_phases(1'b0, 2);
      apply_stimulus(-1);
      wait_for(PH_AD, 99, 2100);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      check_output("abort_cycle_count", count_ap, 100);
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_output("abort_phase", phase, PH_IDLE);
      check_output("abort_count", count_ap, 0);
      check_output("abort_busy", busy, 0);
      repeat (10) @(negedge clk);
      base = step_total;
      push_phases(1'b1, 4);
      apply_stimulus(LAT);
      wait_for(PH_DONE, 0, 4000);
      @(negedge clk);
      check_output("run3_steps", step_total - base, LAT);

      $display("[TB] run 4: asynchronous reset mid-ENC");
      push_phases(1'b0, 3);
      apply_stimulus(-1);
      wait_for(PH_ENC, 50, 2500);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("midrun_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);

      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_output("idle_abort_phase", phase, PH_IDLE);
      repeat (10) @(negedge clk);

      check_output("phase_queue_left", exp_phase_q.size(), 0);
      check_output("done_queue_left", exp_done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
